tree_serializer_feeder: RTL
===========================

# tree_serializer_feeder

Upstream word-rate feeder for `tree_serializer`. It accepts parallel words from fabric over a valid/ready handshake and buffers them in a small FIFO. It presents one stable word on `PAR_OUT` for exactly `INPUTS_NUM` bit-clock cycles, which is the hold time the serializer tree needs on its `PAR_IN`. An idle pattern is inserted whenever no data is available.

## Interface

Parameters:
- `INPUTS_NUM`, default 8: word width, which equals the serializer `INPUTS_NUM`. Must be a power of 2 and ≥2.
- `FIFO_DEPTH`, default 4: number of buffered words. Must be a power of 2 and ≥2.
- `PRIME_LEVEL`, default 2: FIFO occupancy required before leaving PRIME. Range 1..`FIFO_DEPTH`.
- `IDLE_WORD`, default `{INPUTS_NUM/2{2'b01}}`: word sent when no data is available.

Ports:
- `CLK` in 1: bit clock, the same clock as the serializer `CLK`.
- `RESET` in 1: asynchronous, active-low reset.
- `ENABLE` in 1: run request, synchronous.
- `IN_VALID` in 1: input word valid.
- `IN_READY` out 1: FIFO can accept a word.
- `IN_DATA` in `INPUTS_NUM`: input word.
- `PAR_OUT` out `INPUTS_NUM`: word to the serializer `PAR_IN`. Registered.
- `WORD_STROBE` out 1: one-cycle pulse in the first cycle a new `PAR_OUT` is valid.
- `FIFO_LEVEL` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `UNDERFLOW` out 1: sticky flag, set on a data underrun while in RUN.
- `UNDERFLOW_CLR` in 1: synchronous clear for `UNDERFLOW`.

## Operation

- **FIFO**
  - Push when `IN_VALID && IN_READY`.
  - `IN_READY = (FIFO_LEVEL < FIFO_DEPTH)`. A pop in the same cycle does not free a slot for that cycle's push.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Phase counter `PHASE`**
  - Counts `0..INPUTS_NUM-1` and wraps.
  - Held at 0 in STOP.
  - A load boundary is the cycle with `PHASE == INPUTS_NUM-1`.
- **State machine**
  - **STOP** (reset state)
    - `PAR_OUT = IDLE_WORD`; `PHASE` held at 0; no pops.
    - Pushes are still accepted.
    - When `ENABLE` is 1, go to PRIME.
  - **PRIME**
    - `PHASE` runs; `IDLE_WORD` is loaded at each boundary.
    - At a boundary with `FIFO_LEVEL >= PRIME_LEVEL`, pop the head into `PAR_OUT` and go to RUN.
  - **RUN**
    - At each boundary, if the FIFO is non-empty, pop the head into `PAR_OUT`.
    - If it is empty, load `IDLE_WORD`, set `UNDERFLOW`, and go to PRIME.
  - **Any state**
    - When `ENABLE` is 0, go to STOP on the next edge: `PHASE` becomes 0 and `PAR_OUT` becomes `IDLE_WORD`.
    - FIFO contents are retained.
- **Boundary conditions**
  - The empty check at a boundary uses the pre-edge occupancy. A word pushed in the boundary cycle is not sent until the next boundary.
  - Simultaneous push and pop: `FIFO_LEVEL` is unchanged.
  - `UNDERFLOW_CLR` and a new underflow in the same cycle: the flag stays set (set wins).

## Timing

- Reset values of outputs:
  - `PAR_OUT = IDLE_WORD`
  - `WORD_STROBE = 0`
  - `FIFO_LEVEL = 0`
  - `UNDERFLOW = 0`
  - `IN_READY = 1`
  - State = STOP, `PHASE = 0`, pointers = 0.
- `PAR_OUT` changes only on the edge that ends a boundary cycle. It is then stable for exactly `INPUTS_NUM` cycles.
- `WORD_STROBE` is high in the cycle where `PHASE == 0`, in PRIME and RUN only.
- Latency:
  - A word pushed at cycle t into an empty FIFO in RUN appears on `PAR_OUT` after the first boundary cycle that is ≥t+1.
  - Worst case is `INPUTS_NUM+1` cycles.
- `ENABLE` 0→1 at cycle t: PRIME starts at t+1, with `PHASE = 0` at t+1.
- `FIFO_LEVEL` is registered and updates the cycle after a push or pop.
- Asserting `RESET` mid-word immediately forces all reset values.
  - Words in the FIFO are lost.

## Configuration

- Macro: `TREE_FEEDER_STATS_EN`.
- When defined, the block adds two 16-bit outputs:
  - `WORDS_SENT`: count of FIFO words loaded into `PAR_OUT`.
  - `IDLES_SENT`: count of `IDLE_WORD` loads in PRIME or RUN (STOP excluded).
  - Both saturate at 16'hFFFF.
  - Both reset to 0 and are cleared by `UNDERFLOW_CLR`.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

## Test plan

- **Reset/idle:** `RESET` low, then high, with `ENABLE` = 0 for 20 cycles → `PAR_OUT = 8'h55`, `WORD_STROBE` never high, `IN_READY = 1`.
- **Priming:** `ENABLE` = 1 and an empty FIFO for 3 words, then push `8'hA1` and `8'hB2` → `PAR_OUT` shows `8'hA1` at the first boundary where level ≥2 is sampled, then `8'hB2` exactly 8 cycles later.
- **Underflow:** continue the priming run with no further pushes → at the next boundary `PAR_OUT = 8'h55`, `UNDERFLOW = 1`, state = PRIME. Pulse `UNDERFLOW_CLR` → the flag reads 0 on the next cycle.
- **Full/back-pressure:** hold `IN_VALID` high with words 1..6 while in STOP → `FIFO_LEVEL = 4`, `IN_READY` = 0. Words 5 and 6 are not accepted until a pop occurs, and output order is 1,2,3,4,5,6 with no loss.
- **Boundary push:** with an empty FIFO in RUN, push `8'h3C` exactly in a boundary cycle → `IDLE_WORD` is loaded and UNDERFLOW is set. `8'h3C` is output only after re-priming.
- **Mid-word abort:** drop `ENABLE` at `PHASE = 3` → the next cycle has `PAR_OUT = IDLE_WORD` and `PHASE = 0`. Re-enable → FIFO contents resume in order. Repeat with `RESET` low at `PHASE = 5` → all outputs show reset values asynchronously.

Source files
------------

// File: rtl/tree_serializer_feeder.sv
// Word-rate feeder for tree_serializer: a small FIFO that holds each word on PAR_OUT for INPUTS_NUM cycles.
// Optional stats counters (WORDS_SENT/IDLES_SENT) are enabled with `define TREE_FEEDER_STATS_EN.
module tree_serializer_feeder #(
  parameter int INPUTS_NUM  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2,
  parameter logic [INPUTS_NUM-1:0] IDLE_WORD = {INPUTS_NUM/2{2'b01}}
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [INPUTS_NUM-1:0]         IN_DATA,
  output logic [INPUTS_NUM-1:0]         PAR_OUT,
  output logic                          WORD_STROBE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          UNDERFLOW,
  input  logic                          UNDERFLOW_CLR
`ifdef TREE_FEEDER_STATS_EN
  ,
  output logic [15:0]                   WORDS_SENT,
  output logic [15:0]                   IDLES_SENT
`endif
);
  localparam int PW = $clog2(INPUTS_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);
  localparam logic [PW-1:0] LAST_PH = PW'(INPUTS_NUM - 1);

  typedef enum logic [1:0] {STOP, PRIME, RUN} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         phase, phase_nxt;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [INPUTS_NUM-1:0] mem [FIFO_DEPTH];
  logic                  push, pop, load_idle, uf_set, boundary;

  // Readiness uses the registered level, so a same-cycle pop never frees a slot.
  assign IN_READY    = (FIFO_LEVEL < DEPTH_L);
  assign push        = IN_VALID && IN_READY;
  assign boundary    = (phase == LAST_PH);
  assign WORD_STROBE = (state != STOP) && (phase == '0);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase + 1'b1;
    pop       = 1'b0;
    load_idle = 1'b0;
    uf_set    = 1'b0;
    if (!ENABLE) begin
      state_nxt = STOP;
      phase_nxt = '0;
    end else begin
      case (state)
        STOP: begin
          state_nxt = PRIME;
          phase_nxt = '0;
        end
        PRIME: if (boundary) begin
          if (FIFO_LEVEL >= PRIME_L) begin
            pop       = 1'b1;
            state_nxt = RUN;
          end else begin
            load_idle = 1'b1;
          end
        end
        RUN: if (boundary) begin
          if (FIFO_LEVEL != '0) begin
            pop = 1'b1;
          end else begin
            load_idle = 1'b1;
            uf_set    = 1'b1;
            state_nxt = PRIME;
          end
        end
        default: state_nxt = STOP;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= STOP;
      phase      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
      PAR_OUT    <= IDLE_WORD;
      UNDERFLOW  <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
        2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
        default: FIFO_LEVEL <= FIFO_LEVEL;
      endcase
      if (!ENABLE || load_idle) PAR_OUT <= IDLE_WORD;
      else if (pop)             PAR_OUT <= mem[rd_ptr];
      // A new underrun outranks a clear in the same cycle.
      if (uf_set)             UNDERFLOW <= 1'b1;
      else if (UNDERFLOW_CLR) UNDERFLOW <= 1'b0;
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= IN_DATA;
  end

`ifdef TREE_FEEDER_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WORDS_SENT <= '0;
      IDLES_SENT <= '0;
    end else if (UNDERFLOW_CLR) begin
      WORDS_SENT <= '0;
      IDLES_SENT <= '0;
    end else begin
      if (pop && WORDS_SENT != 16'hFFFF)       WORDS_SENT <= WORDS_SENT + 1'b1;
      if (load_idle && IDLES_SENT != 16'hFFFF) IDLES_SENT <= IDLES_SENT + 1'b1;
    end
  end
`endif
endmodule
